// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end: instruction/address widths,
// the PC of instruction memory word 0, and the NOP encoding.
package mips_pkg;
    localparam int          INSTR_W   = 32;
    localparam int          ADDR_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'h0000_31B0;
    localparam logic [31:0] NOP       = 32'h0000_0000;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a flush input and an occupancy count.
// DEPTH must be a power of two so the pointers wrap without any compare logic.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != (PW+1)'(DEPTH)) || do_pop);

    // Storage array: data only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and count; flush empties the FIFO like a reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + (PW+1)'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - (PW+1)'(1);
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests for the current PC,
// pairs returned words with their PCs and hands them to decode over valid/ready.
// On redirect all buffered words are dropped and responses still in flight are
// counted off in drop_cnt so they never reach decode.
module fetch_unit import mips_pkg::*; #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = mips_pkg::BASE_ADDR,
    parameter int          AW        = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               redirect,
    output logic               pc_stall,
    output logic               imem_req,
    output logic [AW-1:0]      imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               spurious_rsp
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]      tag_count;
    logic [CW-1:0]      data_count;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      drop_cnt;
    logic [CW-1:0]      drop_nxt;
    logic [CW-1:0]      pending;
    logic [ADDR_W-1:0]  tag_head;
    logic [INSTR_W-1:0] data_head;
    logic               accept;
    logic               id_pop;
    logic               rsp_live;
    logic               data_push;

    // Requests accepted but whose word has not come back yet.
    assign inflight = tag_count - data_count;

    // No new requests while stale responses are still being drained.
    assign imem_req  = !rst && !redirect && (tag_count < CW'(DEPTH)) && (drop_cnt == '0);
    assign imem_addr = AW'((pc_in - BASE_ADDR) >> 2);
    assign accept    = imem_req && imem_gnt;
    assign pc_stall  = !accept;

    assign rsp_live  = imem_rvalid && (drop_cnt == '0) && (inflight != '0);
    assign data_push = rsp_live && !redirect;

    assign id_valid  = !rst && (data_count != '0);
    assign id_pop    = id_valid && id_ready && !redirect;
    assign id_instr  = id_valid ? data_head : NOP;
    assign id_pc     = id_valid ? tag_head  : '0;

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tagq (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (accept),
        .din   (pc_in),
        .pop   (id_pop),
        .dout  (tag_head),
        .count (tag_count)
    );

    sync_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_dataq (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (data_push),
        .din   (imem_rdata),
        .pop   (id_pop),
        .dout  (data_head),
        .count (data_count)
    );

    // Responses still owed after a redirect; a response arriving in the redirect
    // cycle itself is already consumed and is not counted again.
    assign pending = drop_cnt + inflight;

    // Next value of the drop counter.
    always_comb begin
        drop_nxt = drop_cnt;
        if (redirect) begin
            drop_nxt = pending - CW'(imem_rvalid && (pending != '0));
        end else if (imem_rvalid && (drop_cnt != '0)) begin
            drop_nxt = drop_cnt - CW'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_nxt;
        end
    end

    // Sticky flag: a response arrived when nothing was outstanding or owed.
    always_ff @(posedge clk) begin
        if (rst) begin
            spurious_rsp <= 1'b0;
        end else if (imem_rvalid && (drop_cnt == '0) && (inflight == '0)) begin
            spurious_rsp <= 1'b1;
        end
    end
endmodule
